// File: rtl/bf16_fma_pkg.sv
// Shared types and constants for the bf16 multiply-add arbiter.
//   BF16_W    : bfloat16 word width
//   BF16_ZERO : value driven onto idle operand buses
//   req_id_t  : requester identifier (0 or 1)
//   shadow_t  : one shadow-pipeline stage {valid, id}
package bf16_fma_pkg;

   localparam int          BF16_W    = 16;
   localparam logic [15:0] BF16_ZERO = 16'h0000;

   typedef logic req_id_t;

   typedef struct packed {
      logic    valid;
      req_id_t id;
   } shadow_t;

endpackage

// File: rtl/fma_tag_pipe.sv
// Fixed-depth register delay line with asynchronous active-high reset.
// Used both for the operand-C alignment line and for the {valid, id}
// shadow pipeline that tracks operations through the datapath.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset, clears every stage
//   din  : value entering stage 1
//   dout : value leaving stage DEPTH (din delayed by DEPTH cycles)
module fma_tag_pipe #(
   parameter int DEPTH = 3,
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= din;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign dout = stage[DEPTH-1];

endmodule

// File: rtl/bf16_fma_arbiter.sv
// Two-requester front end for a shared, untagged bf16 multiply-add datapath.
// One operation is issued per cycle; operand C is delayed MULT_LAT cycles so
// it reaches the adder together with the product; a {valid, id} shadow
// pipeline of PIPE_LAT stages routes each result back to its issuer.
//
// Build option: define FMA_ARB_RR_EN for round-robin arbitration between the
// two requesters. Without it requester 0 has fixed priority.
//
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   reqN_valid / reqN_ready       : request handshake (ready is combinational)
//   reqN_a, reqN_b, reqN_c        : bf16 operands, result = a*b + c
//   fma_a, fma_b                  : multiplier operands (zero when idle)
//   fma_c                         : adder second operand (aligned C)
//   fma_result                    : adder output
//   resp0_valid, resp1_valid      : one-cycle response pulses
//   resp_data                     : registered result, holds when idle
//   busy                          : any operation in flight
module bf16_fma_arbiter
   import bf16_fma_pkg::*;
#(
   parameter int MULT_LAT = 3,
   parameter int ADD_LAT  = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [15:0] req0_a,
   input  logic [15:0] req0_b,
   input  logic [15:0] req0_c,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [15:0] req1_a,
   input  logic [15:0] req1_b,
   input  logic [15:0] req1_c,
   output logic [15:0] fma_a,
   output logic [15:0] fma_b,
   output logic [15:0] fma_c,
   input  logic [15:0] fma_result,
   output logic        resp0_valid,
   output logic        resp1_valid,
   output logic [15:0] resp_data,
   output logic        busy
);

   localparam int PIPE_LAT = MULT_LAT + ADD_LAT;
   localparam int CNT_W    = $clog2(PIPE_LAT + 1);

   logic                 v0, v1;
   logic                 gnt0, gnt1, any_gnt;
   logic [BF16_W-1:0]    c_in;
   shadow_t              tag_in, tag_out;
   logic [CNT_W-1:0]     inflight;
   logic [CNT_W-1:0]     inflight_nxt;

   // Nothing is granted while reset is held so every output reads zero.
   assign v0 = req0_valid & ~rst;
   assign v1 = req1_valid & ~rst;

`ifdef FMA_ARB_RR_EN
   // rr_ptr names the winner when both requesters are valid; it only moves
   // on a contended grant so a lone requester cannot starve the other later.
   req_id_t rr_ptr;

   always_comb begin
      gnt1 = v1 & (~v0 | rr_ptr);
      gnt0 = v0 & ~gnt1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)            rr_ptr <= 1'b0;
      else if (v0 && v1)  rr_ptr <= ~rr_ptr;
   end
`else
   always_comb begin
      gnt0 = v0;
      gnt1 = v1 & ~v0;
   end
`endif

   assign any_gnt    = gnt0 | gnt1;
   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   always_comb begin
      fma_a = BF16_ZERO;
      fma_b = BF16_ZERO;
      c_in  = BF16_ZERO;
      if (gnt0) begin
         fma_a = req0_a;
         fma_b = req0_b;
         c_in  = req0_c;
      end else if (gnt1) begin
         fma_a = req1_a;
         fma_b = req1_b;
         c_in  = req1_c;
      end
   end

   always_comb begin
      tag_in.valid = any_gnt;
      tag_in.id    = gnt1;
   end

   fma_tag_pipe #(
      .DEPTH (MULT_LAT),
      .WIDTH (BF16_W)
   ) u_c_delay (
      .clk  (clk),
      .rst  (rst),
      .din  (c_in),
      .dout (fma_c)
   );

   fma_tag_pipe #(
      .DEPTH (PIPE_LAT),
      .WIDTH ($bits(shadow_t))
   ) u_tag_pipe (
      .clk  (clk),
      .rst  (rst),
      .din  (tag_in),
      .dout (tag_out)
   );

   // Count of valid shadow stages; equivalent to OR-ing every stage valid
   // without exposing the internal stages of the delay line.
   assign inflight_nxt = inflight + CNT_W'(any_gnt) - CNT_W'(tag_out.valid);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp0_valid <= 1'b0;
         resp1_valid <= 1'b0;
         resp_data   <= BF16_ZERO;
         inflight    <= '0;
      end else begin
         resp0_valid <= tag_out.valid & ~tag_out.id;
         resp1_valid <= tag_out.valid &  tag_out.id;
         if (tag_out.valid) resp_data <= fma_result;
         inflight    <= inflight_nxt;
      end
   end

   assign busy = (inflight != '0) | resp0_valid | resp1_valid;

endmodule

// File: tb/tb_bf16_fma_arbiter.sv
module tb_bf16_fma_arbiter;

   localparam int PIPE_LAT = 6;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [15:0] req0_a = '0, req0_b = '0, req0_c = '0;
   logic [15:0] req1_a = '0, req1_b = '0, req1_c = '0;
   logic [15:0] fma_a, fma_b, fma_c, fma_result;
   logic        resp0_valid, resp1_valid, busy;
   logic [15:0] resp_data;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   bf16_fma_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_a      (req0_a),
      .req0_b      (req0_b),
      .req0_c      (req0_c),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_a      (req1_a),
      .req1_b      (req1_b),
      .req1_c      (req1_c),
      .fma_a       (fma_a),
      .fma_b       (fma_b),
      .fma_c       (fma_c),
      .fma_result  (fma_result),
      .resp0_valid (resp0_valid),
      .resp1_valid (resp1_valid),
      .resp_data   (resp_data),
      .busy        (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in arithmetic: true bf16 results for the named vectors, an
   // operand-mixing function otherwise (the arbiter never inspects data).
   function automatic logic [15:0] dp_fn(input logic [15:0] a, b, c);
      if (a == 16'h4000 && b == 16'h4040 && c == 16'h3F80) return 16'h40E0;
      if (a == 16'h3F80 && b == 16'h3F80 && c == 16'h3F00) return 16'h3FC0;
      if (a == 16'h4000 && b == 16'h4000 && c == 16'h0000) return 16'h4080;
      return ({a[7:0], a[15:8]} ^ b) + c;
   endfunction

   // Datapath model: 3-stage multiplier carrying A/B, C joins at the adder
   // input, 3-stage adder.
   logic [15:0] ma1 = '0, ma2 = '0, ma3 = '0, mb1 = '0, mb2 = '0, mb3 = '0;
   logic [15:0] ad1 = '0, ad2 = '0, ad3 = '0;
   always @(posedge clk) begin
      ma1 <= fma_a; ma2 <= ma1; ma3 <= ma2;
      mb1 <= fma_b; mb2 <= mb1; mb3 <= mb2;
      ad1 <= dp_fn(ma3, mb3, fma_c); ad2 <= ad1; ad3 <= ad2;
   end
   assign fma_result = ad3;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        id;
      logic [15:0] data;
      int          issue;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] cq[$];
   logic [15:0] last_data = '0;
   exp_t        e;
   logic        got, busy_exp;
   logic [15:0] c_exp, a_exp, b_exp;

   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         cq = '{16'h0, 16'h0, 16'h0};
         last_data = '0;
      end else begin
         got = resp0_valid | resp1_valid;
         if (resp0_valid && resp1_valid) chk("resp_both_pulse", 1, 0);
         if (got) begin
            if (sb.size() == 0) chk("resp_unexpected", {resp1_valid, resp0_valid}, 0);
            else begin
               e = sb.pop_front();
               chk("resp_id", resp1_valid, e.id);
               chk("resp_data", resp_data, e.data);
               chk("resp_latency", cyc - e.issue, PIPE_LAT + 1);
               last_data = e.data;
            end
         end else begin
            chk("resp_hold", resp_data, last_data);
         end
         busy_exp = got || (sb.size() > 0 && sb[0].issue < cyc);
         chk("busy", busy, busy_exp);
         chk("ready_without_valid", (req0_ready & ~req0_valid) | (req1_ready & ~req1_valid), 0);
         chk("ready_onehot", req0_ready & req1_ready, 0);
         a_exp = '0; b_exp = '0; c_exp = '0;
         if (req0_valid && req0_ready) begin
            a_exp = req0_a; b_exp = req0_b; c_exp = req0_c;
            sb.push_back('{1'b0, dp_fn(req0_a, req0_b, req0_c), cyc});
         end else if (req1_valid && req1_ready) begin
            a_exp = req1_a; b_exp = req1_b; c_exp = req1_c;
            sb.push_back('{1'b1, dp_fn(req1_a, req1_b, req1_c), cyc});
         end
         chk("fma_ab", {fma_a, fma_b}, {a_exp, b_exp});
         cq.push_back(c_exp);
         chk("fma_c_align", fma_c, cq.pop_front());
      end
   end

   task automatic drive(input logic v0, input logic [15:0] a0, b0, c0,
                        input logic v1, input logic [15:0] a1, b1, c1);
      @(posedge clk);
      #1;
      req0_valid = v0; req0_a = a0; req0_b = b0; req0_c = c0;
      req1_valid = v1; req1_a = a1; req1_b = b1; req1_c = c1;
   endtask

   task automatic drive_idle();
      drive(0, 16'h0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 16'h0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      drive_idle();
      while ((busy || sb.size() != 0) && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_in_time", n < 40, 1);
      chk("scoreboard_empty", sb.size(), 0);
   endtask

   typedef struct {
      logic        v0;
      logic [15:0] a0, b0, c0;
      logic        v1;
      logic [15:0] a1, b1, c1;
      logic        r0_rr, r1_rr, r0_fp, r1_fp;
   } vec_t;

   vec_t tbl[10];
   logic er0, er1;
   logic [15:0] sa, sb_op, sc;

   initial begin
      tbl[0] = '{1, 16'h4000, 16'h4040, 16'h3F80, 0, 16'h0, 16'h0, 16'h0, 1, 0, 1, 0};
      tbl[1] = '{0, 16'h0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0};
      tbl[2] = '{1, 16'h3F80, 16'h3F80, 16'h3F00, 1, 16'h4000, 16'h4000, 16'h0000, 1, 0, 1, 0};
      tbl[3] = '{1, 16'h3F80, 16'h3F80, 16'h3F00, 1, 16'h4000, 16'h4000, 16'h0000, 0, 1, 1, 0};
      tbl[4] = '{1, 16'h3F80, 16'h3F80, 16'h3F00, 1, 16'h4000, 16'h4000, 16'h0000, 1, 0, 1, 0};
      tbl[5] = '{1, 16'h3F80, 16'h3F80, 16'h3F00, 1, 16'h4000, 16'h4000, 16'h0000, 0, 1, 1, 0};
      tbl[6] = '{0, 16'h0, 16'h0, 16'h0, 1, 16'h4000, 16'h4000, 16'h0000, 0, 1, 0, 1};
      tbl[7] = '{0, 16'h0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0};
      tbl[8] = '{0, 16'h0, 16'h0, 16'h0, 1, 16'h1234, 16'h5678, 16'h9ABC, 0, 1, 0, 1};
      tbl[9] = '{1, 16'h0F0F, 16'hF0F0, 16'h1111, 0, 16'h0, 16'h0, 16'h0, 1, 0, 1, 0};

      // Reset with a request pending: nothing may be granted or driven.
      req0_valid = 1; req0_a = 16'h4000; req0_b = 16'h4040; req0_c = 16'h3F80;
      @(posedge clk);
      #1;
      chk("rst_ready0", req0_ready, 0);
      chk("rst_fma_a", fma_a, 16'h0);
      chk("rst_fma_c", fma_c, 16'h0);
      chk("rst_resp", {resp0_valid, resp1_valid, busy}, 0);
      chk("rst_resp_data", resp_data, 16'h0);
      req0_valid = 0;
      @(posedge clk);
      #1;
      rst = 0;

      // Idle: datapath inputs zero, not busy.
      repeat (4) drive_idle();
      chk("idle_fma", {fma_a, fma_b, fma_c}, 0);
      chk("idle_busy", busy, 0);

      // Arbitration table.
      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].v0, tbl[i].a0, tbl[i].b0, tbl[i].c0,
               tbl[i].v1, tbl[i].a1, tbl[i].b1, tbl[i].c1);
`ifdef FMA_ARB_RR_EN
         er0 = tbl[i].r0_rr; er1 = tbl[i].r1_rr;
`else
         er0 = tbl[i].r0_fp; er1 = tbl[i].r1_fp;
`endif
         #1;
         chk($sformatf("tbl%0d_ready0", i), req0_ready, er0);
         chk($sformatf("tbl%0d_ready1", i), req1_ready, er1);
      end
      drain();

      // Back-to-back requester 1 stream with changing C.
      for (int i = 0; i < 10; i++) begin
         sa = 16'h3F80 + 16'(i);
         sb_op = 16'h4000 - 16'(i * 3);
         sc = 16'h3C00 + 16'(i * 37);
         drive(0, 16'h0, 16'h0, 16'h0, 1, sa, sb_op, sc);
         #1;
         chk("stream_ready1", req1_ready, 1);
      end
      drain();

      // Reset with three operations in flight.
      drive(1, 16'h1111, 16'h2222, 16'h3333, 1, 16'h4444, 16'h5555, 16'h6666);
      drive(1, 16'h7777, 16'h8888, 16'h9999, 0, 16'h0, 16'h0, 16'h0);
      drive(0, 16'h0, 16'h0, 16'h0, 1, 16'hAAAA, 16'hBBBB, 16'hCCCC);
      @(posedge clk);
      #2;
      rst = 1;
      #1;
      chk("midrst_resp", {resp0_valid, resp1_valid}, 0);
      chk("midrst_resp_data", resp_data, 16'h0);
      chk("midrst_busy", busy, 0);
      chk("midrst_fma", {fma_a, fma_b, fma_c}, 0);
      chk("midrst_ready1", req1_ready, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      req1_valid = 0;
      repeat (12) drive_idle();
      chk("flush_no_busy", busy, 0);

      // Pointer back at requester 0 after reset.
      drive(1, 16'h4000, 16'h4040, 16'h3F80, 1, 16'h4000, 16'h4000, 16'h0000);
      #1;
      chk("post_rst_ready0", req0_ready, 1);
      chk("post_rst_ready1", req1_ready, 0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bf16_fma_arbiter.md
Name: bf16_fma_arbiter

Overview:
Shares one multiply-add datapath between two requesters. The datapath is the pipelined bfloat16 multiplier feeding the pipelined bfloat16 add/sub, with no valid or tag signals of its own. The block:
- arbitrates one issue per cycle;
- delays operand C so it meets the product at the adder input;
- carries requester ID and valid through a shadow pipeline;
- returns each result to the requester that issued it.

It sits between compute clients and the top-level multiply-add wrapper.

Parameters:
MULT_LAT, 3, clock cycles from A/B presented at multiplier to product at adder input.
ADD_LAT, 3, clock cycles from adder inputs to fma_result.
PIPE_LAT, MULT_LAT+ADD_LAT, derived total latency; not overridable.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req0_valid  in  1  requester 0 operation available
req0_ready  out  1  requester 0 accepted this cycle
req0_a, req0_b, req0_c  in  16 each  requester 0 bf16 operands; result = a*b+c
req1_valid, req1_ready, req1_a, req1_b, req1_c  same as requester 0, for requester 1
fma_a, fma_b  out  16 each  multiplier operands
fma_c  out  16  adder second operand
fma_result  in  16  adder output
resp0_valid  out  1  one-cycle pulse; resp_data belongs to requester 0
resp1_valid  out  1  one-cycle pulse; resp_data belongs to requester 1
resp_data  out  16  registered result
busy  out  1  any operation in flight

Behaviour:
- Reset (async, rst=1): all outputs 0 (resp*_valid=0, resp_data=16'h0000, busy=0). Shadow pipeline cleared. C delay line cleared. RR pointer set to requester 0. In-flight ops are dropped, no response is ever produced for them, and outputs stay 0 until rst deasserts.
- Handshake: accept when valid & ready at a rising edge. reqN_ready is combinational from the arbitration and is never asserted without reqN_valid. Valid must not depend on ready. At most one ready per cycle.
- No backpressure anywhere. A request is accepted every cycle that any valid is high.
- Arbitration:
  - One requester valid: it wins.
  - Both valid: the winner is the requester the RR pointer names.
  - The pointer flips to the other requester only after a grant while both were valid.
- Issue (cycle t, grant to N):
  - fma_a/fma_b = reqN_a/b combinationally in cycle t.
  - No grant: fma_a/fma_b = 16'h0000.
- C alignment: reqN_c enters a MULT_LAT-deep register delay line (zero when no grant). fma_c in cycle t+MULT_LAT equals the C accepted in cycle t.
- Shadow pipeline: PIPE_LAT stages of {valid, id}. Stage k holds cycle t's entry during cycle t+k.
- Response: in cycle t+PIPE_LAT the last stage is sampled together with fma_result into the output registers. resp_data and respN_valid are therefore high in cycle t+PIPE_LAT+1, exactly one cycle per accepted op.
- resp_data holds its last value when no response is valid.
- Ordering: responses are in issue order, and back-to-back issues give back-to-back responses.
- busy = OR of all shadow stages plus the response register valid.
- Arithmetic, rounding and special values are the datapath's own; the block never modifies data.

Optional Feature:
FMA_ARB_RR_EN
- Defined: round-robin arbitration as above.
- Undefined: fixed priority, requester 0 always wins. The RR pointer is removed, and requester 1 is granted only when req0_valid=0.

Decomposition:
- Package bf16_fma_pkg holds:
  - BF16_W=16;
  - BF16_ZERO=16'h0000;
  - requester-id type (1 bit);
  - shadow-stage struct {valid, id}.
- Sub-module fma_tag_pipe is a parameterised delay line with depth and width parameters and async reset. It is instantiated twice: once for the C delay (MULT_LAT×16) and once for the tag pipeline (PIPE_LAT×{valid,id}).

Test Plan:
- req0 only, a=16'h4000 b=16'h4040 c=16'h3F80 (2*3+1) -> resp0_valid exactly PIPE_LAT+1 cycles after accept, resp_data=16'h40E0, resp1_valid never asserted.
- Both valid for 4 cycles: req0 {1,1,0.5}=0x3F80/0x3F80/0x3F00, req1 {2,2,0}=0x4000/0x4000/0x0000 -> grants alternate 0,1,0,1 (RR build). Responses alternate resp0 0x3FC0 and resp1 0x4080 on consecutive cycles.
- Same as previous with FMA_ARB_RR_EN undefined -> req1_ready stays 0 and only resp0 pulses. After req0 drops, req1 is accepted the next cycle.
- Back-to-back req1 stream for 10 cycles with changing c -> 10 consecutive resp1 pulses in order, and each fma_c matches its op's c at issue+MULT_LAT.
- Assert rst with 3 ops in flight -> all outputs 0 immediately. No response for the flushed ops after release. A new op issued after release returns correctly.
- No requests -> fma_a=fma_b=fma_c=0, busy=0, no resp pulses.
